// File: rtl/svpwm_phase_scheduler_if.sv
// Parameter-set handshake between the SVPWM sector/dwell source and the phase scheduler.
interface svpwm_phase_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sector;
    logic [CNT_W-1:0] in_t0;
    logic [CNT_W-1:0] in_t1;
    logic [CNT_W-1:0] in_t2;

    modport master (
        output in_valid, in_sector, in_t0, in_t1, in_t2,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_sector, in_t0, in_t1, in_t2,
        output in_ready
    );
endinterface

// File: rtl/svpwm_phase_scheduler.sv
// Symmetric Z1-LOW-HIGH-Z2 space-vector PWM period sequencer with a one-entry
// shadow buffer for the next sector/dwell set.
//
//   state  | meaning
//   IDLE   | no period running, zero vector driven
//   Z1     | first half of the zero-vector dwell (T0>>1)
//   LOW    | low adjacent vector dwell (T1)
//   HIGH   | high adjacent vector dwell (T2)
//   Z2     | second half of the zero-vector dwell (T0-(T0>>1))
module svpwm_phase_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    svpwm_phase_scheduler_if.slave i_prm,
    output logic [2:0]             o_sector,
    output logic                   o_u_0,
    output logic                   o_u_low,
    output logic                   o_u_high,
    output logic                   o_period_start,
    output logic                   o_busy,
    output logic                   o_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_Z1   = 3'd1,
        S_LOW  = 3'd2,
        S_HIGH = 3'd3,
        S_Z2   = 3'd4
    } state_t;

    localparam int LW = 4 * CNT_W;

    // Segment lengths packed as {Z2, HIGH, LOW, Z1}; index i maps to state i+1.
    function automatic logic [LW-1:0] seg_lens(input logic [CNT_W-1:0] t0,
                                               input logic [CNT_W-1:0] t1,
                                               input logic [CNT_W-1:0] t2);
        seg_lens = {t0 - (t0 >> 1), t2, t1, t0 >> 1};
    endfunction

    // First non-empty segment at or after index from_idx; S_IDLE when none remain.
    function automatic state_t first_seg(input logic [LW-1:0] lens, input int from_idx);
        first_seg = S_IDLE;
        for (int i = 3; i >= 0; i--) begin
            if (i >= from_idx && lens[i*CNT_W +: CNT_W] != '0) begin
                first_seg = state_t'(3'(i + 1));
            end
        end
    endfunction

    function automatic logic [CNT_W-1:0] seg_len(input logic [LW-1:0] lens, input state_t s);
        seg_len = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(s) == i + 1) begin
                seg_len = lens[i*CNT_W +: CNT_W];
            end
        end
    endfunction

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;

    logic             r_sh_full;
    logic [2:0]       r_sh_sector;
    logic [CNT_W-1:0] r_sh_t0, r_sh_t1, r_sh_t2;

    logic             r_act_loaded;
    logic [2:0]       r_act_sector;
    logic [CNT_W-1:0] r_act_t0, r_act_t1, r_act_t2;

    logic [2:0]       r_sector;
    logic             r_u_0, r_u_low, r_u_high, r_ps, r_busy, r_err;

    logic [LW-1:0]    w_act_lens, w_sel_lens;
    logic [2:0]       w_sel_sector;
    logic             w_sel_illegal, w_nxt_illegal;
    state_t           w_sel_first, w_mid_next;
    logic             w_start, w_end;
    logic             w_accept;

    assign i_prm.in_ready = !r_sh_full;
    assign w_accept       = i_prm.in_valid && !r_sh_full;

    // Next segment selection; a new period is entered from IDLE or when the last non-empty segment ends.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_start       = 1'b0;
        w_end         = 1'b0;
        w_act_lens    = seg_lens(r_act_t0, r_act_t1, r_act_t2);
        w_sel_lens    = r_sh_full ? seg_lens(r_sh_t0, r_sh_t1, r_sh_t2) : w_act_lens;
        w_sel_sector  = r_sh_full ? r_sh_sector : r_act_sector;
        w_sel_illegal = (w_sel_sector > 3'd5);
        w_sel_first   = first_seg(w_sel_lens, 0);
        w_mid_next    = first_seg(w_act_lens, int'(r_state));

        if (r_state == S_IDLE) begin
            w_start = i_enable && (r_sh_full || r_act_loaded);
        end else if (r_cnt == CNT_W'(1)) begin
            if (w_mid_next != S_IDLE) begin
                w_nxt_state = w_mid_next;
                w_nxt_cnt   = seg_len(w_act_lens, w_mid_next);
            end else begin
                w_end = 1'b1;
            end
        end else begin
            w_nxt_cnt = r_cnt - CNT_W'(1);
        end

        if (w_end) begin
            if (i_enable) begin
                w_start = 1'b1;
            end else begin
                w_nxt_state = S_IDLE;
            end
        end

        // An all-zero set still runs a one-cycle period on the zero vector.
        if (w_start) begin
            if (w_sel_first == S_IDLE) begin
                w_nxt_state = S_Z2;
                w_nxt_cnt   = CNT_W'(1);
            end else begin
                w_nxt_state = w_sel_first;
                w_nxt_cnt   = seg_len(w_sel_lens, w_sel_first);
            end
        end

        w_nxt_illegal = w_start ? w_sel_illegal : (r_act_sector > 3'd5);
    end

    // State and segment down-counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Shadow slot: filled by the handshake, drained when a period start loads it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_full   <= 1'b0;
            r_sh_sector <= '0;
            r_sh_t0     <= '0;
            r_sh_t1     <= '0;
            r_sh_t2     <= '0;
        end else if (w_accept) begin
            r_sh_full   <= 1'b1;
            r_sh_sector <= i_prm.in_sector;
            r_sh_t0     <= i_prm.in_t0;
            r_sh_t1     <= i_prm.in_t1;
            r_sh_t2     <= i_prm.in_t2;
        end else if (w_start && r_sh_full) begin
            r_sh_full   <= 1'b0;
        end
    end

    // Active set, reported sector and sticky illegal-sector flag, all updated at period start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_loaded <= 1'b0;
            r_act_sector <= '0;
            r_act_t0     <= '0;
            r_act_t1     <= '0;
            r_act_t2     <= '0;
            r_sector     <= '0;
            r_err        <= 1'b0;
        end else if (w_start) begin
            if (r_sh_full) begin
                r_act_loaded <= 1'b1;
                r_act_sector <= r_sh_sector;
                r_act_t0     <= r_sh_t0;
                r_act_t1     <= r_sh_t1;
                r_act_t2     <= r_sh_t2;
            end
            r_sector <= w_sel_illegal ? 3'd0 : w_sel_sector;
            if (w_sel_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    // Registered phase outputs; an illegal set holds the zero vector for the whole period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_u_0    <= 1'b1;
            r_u_low  <= 1'b0;
            r_u_high <= 1'b0;
            r_ps     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_u_low  <= (w_nxt_state == S_LOW)  && !w_nxt_illegal;
            r_u_high <= (w_nxt_state == S_HIGH) && !w_nxt_illegal;
            r_u_0    <= !(((w_nxt_state == S_LOW) || (w_nxt_state == S_HIGH)) && !w_nxt_illegal);
            r_ps     <= w_start;
            r_busy   <= (w_nxt_state != S_IDLE);
        end
    end

    assign o_sector       = r_sector;
    assign o_u_0          = r_u_0;
    assign o_u_low        = r_u_low;
    assign o_u_high       = r_u_high;
    assign o_period_start = r_ps;
    assign o_busy         = r_busy;
    assign o_err          = r_err;

endmodule

// File: tb/tb_svpwm_phase_scheduler.sv
// Directed bench for svpwm_phase_scheduler: hand-written phase patterns per period.
module tb_svpwm_phase_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] sector;
    logic       u_0, u_low, u_high, period_start, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    bit         q_pend = 1'b0;
    logic [2:0] q_sec;
    logic [15:0] q_t0, q_t1, q_t2;

    svpwm_phase_scheduler_if #(.CNT_W(16)) prm ();

    svpwm_phase_scheduler #(.CNT_W(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_prm          (prm),
        .o_sector       (sector),
        .o_u_0          (u_0),
        .o_u_low        (u_low),
        .o_u_high       (u_high),
        .o_period_start (period_start),
        .o_busy         (busy),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [2:0] s, input logic [15:0] t0, input logic [15:0] t1,
                         input logic [15:0] t2);
        prm.in_sector = s;
        prm.in_t0     = t0;
        prm.in_t1     = t1;
        prm.in_t2     = t2;
        prm.in_valid  = 1'b1;
    endtask

    // One clock; the source drops VALID after a transfer and then presents any queued offer.
    task automatic tick();
        bit xfer;
        xfer = prm.in_valid && prm.in_ready;
        @(posedge clk);
        #1;
        if (xfer) begin
            prm.in_valid = 1'b0;
            if (q_pend) begin
                q_pend = 1'b0;
                offer(q_sec, q_t0, q_t1, q_t2);
            end
        end
    endtask

    // {u_0,u_low,u_high,sector,period_start,busy,err,in_ready}
    function automatic logic [9:0] full_vec();
        return {u_0, u_low, u_high, sector, period_start, busy, err, prm.in_ready};
    endfunction

    // Checks nper periods of a pattern string (Z/L/H per cycle); first cycle must be a period start.
    task automatic run_pat(input string tag, input string pat, input logic [2:0] sec,
                           input int nper, input bit chk_rdy);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < pat.len(); i++) begin
                logic [2:0] ph;
                logic [7:0] exp_v;
                logic [7:0] c;
                c  = pat[i];
                ph = (c == "L") ? 3'b010 : (c == "H") ? 3'b001 : 3'b100;
                exp_v = {ph, sec, (i == 0), 1'b1};
                chk($sformatf("%s p%0d c%0d phase", tag, p, i),
                    {24'b0, u_0, u_low, u_high, sector, period_start, busy}, {24'b0, exp_v});
                if (chk_rdy) begin
                    chk($sformatf("%s p%0d c%0d ready", tag, p, i), {31'b0, prm.in_ready},
                        {31'b0, (i == 0)});
                end
                tick();
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        prm.in_valid = 1'b0;
        prm.in_sector = '0;
        prm.in_t0    = '0;
        prm.in_t1    = '0;
        prm.in_t2    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_1});
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_reset", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_1});

        enable = 1'b1;
        repeat (3) tick();
        chk("never_loaded_enable", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_1});
        enable = 1'b0;

        offer(3'd2, 16'd4, 16'd3, 16'd5);
        tick();
        chk("loaded_disabled", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_0});
        tick();
        chk("loaded_disabled2", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_0});
        enable = 1'b1;
        tick();
        chk("start_ready", {31'b0, prm.in_ready}, 32'd1);
        run_pat("t2", "ZZLLLHHHHHZZ", 3'd2, 2, 1'b0);

        offer(3'd1, 16'd1, 16'd0, 16'd2);
        run_pat("t2c", "ZZLLLHHHHHZZ", 3'd2, 1, 1'b0);
        offer(3'd3, 16'd0, 16'd0, 16'd0);
        run_pat("t3a", "HHZ", 3'd1, 1, 1'b0);
        run_pat("t3b", "Z", 3'd3, 4, 1'b1);

        offer(3'd0, 16'd2, 16'd2, 16'd2);
        run_pat("t3c", "Z", 3'd3, 2, 1'b0);
        run_pat("t4e0", "ZLLHHZ", 3'd0, 1, 1'b0);

        offer(3'd4, 16'd2, 16'd1, 16'd1);
        q_sec = 3'd5; q_t0 = 16'd0; q_t1 = 16'd1; q_t2 = 16'd0; q_pend = 1'b1;
        run_pat("t4e1", "ZLLHHZ", 3'd0, 1, 1'b1);
        run_pat("t4f", "ZLHZ", 3'd4, 1, 1'b1);
        run_pat("t4g", "L", 3'd5, 2, 1'b1);

        chk("err_clear", {31'b0, err}, 32'd0);
        offer(3'd6, 16'd2, 16'd3, 16'd3);
        run_pat("t4g2", "L", 3'd5, 2, 1'b0);
        chk("err_set", {31'b0, err}, 32'd1);
        run_pat("t5", "ZZZZZZZZ", 3'd0, 2, 1'b0);
        chk("err_sticky", {31'b0, err}, 32'd1);

        enable = 1'b0;
        run_pat("t5stop", "ZZZZZZZZ", 3'd0, 1, 1'b0);
        chk("stopped_idle", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_1_1});
        tick();
        chk("stopped_idle2", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_1_1});

        offer(3'd3, 16'd2, 16'd1, 16'd4);
        tick();
        enable = 1'b1;
        tick();
        chk("t6 start", {24'b0, u_0, u_low, u_high, sector, period_start, busy},
            {24'b0, 8'b100_011_1_1});
        tick();
        chk("t6 low", {24'b0, u_0, u_low, u_high, sector, period_start, busy},
            {24'b0, 8'b010_011_0_1});
        tick();
        chk("t6 high", {24'b0, u_0, u_low, u_high, sector, period_start, busy},
            {24'b0, 8'b001_011_0_1});
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 async reset", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_1});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6 idle after reset", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_1});
        offer(3'd2, 16'd4, 16'd3, 16'd5);
        tick();
        chk("t6 loaded", {22'b0, full_vec()}, {22'b0, 10'b100_000_0_0_0_0});
        tick();
        run_pat("t6j", "ZZLLLHHHHHZZ", 3'd2, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
